// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multipliers: digit encoding, FSM states
// and the triplet recoder.
package booth_pkg;

   // Bit 2 flags a negative digit, bits 1:0 carry the magnitude.
   typedef enum logic [2:0] {
      BOOTH_ZERO = 3'b000,
      BOOTH_POS1 = 3'b001,
      BOOTH_POS2 = 3'b010,
      BOOTH_NEG1 = 3'b101,
      BOOTH_NEG2 = 3'b110
   } booth_digit_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } booth_state_e;

   // Recode {q[1], q[0], q_prev} into a radix-4 Booth digit.
   function automatic booth_digit_e booth_recode(input logic [2:0] triplet);
      booth_digit_e d;
      case (triplet)
         3'b001, 3'b010: d = BOOTH_POS1;
         3'b011:         d = BOOTH_POS2;
         3'b100:         d = BOOTH_NEG2;
         3'b101, 3'b110: d = BOOTH_NEG1;
         default:        d = BOOTH_ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Combinational radix-4 Booth digit: recodes a multiplier triplet and forms
// the signed partial product d*M, one bit wider than M so +/-2M fits.
module booth_r4_digit
   import booth_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       triplet,
   input  logic [WIDTH+1:0] mcand,
   output booth_digit_e     digit,
   output logic [WIDTH+2:0] pp
);

   logic [WIDTH+2:0] m1;
   logic [WIDTH+2:0] m2;

   // Recode the triplet and select/negate the scaled multiplicand.
   always_comb begin
      digit = booth_recode(triplet);
      m1    = {mcand[WIDTH+1], mcand};
      m2    = {mcand, 1'b0};
      pp    = '0;
      unique case (digit)
         BOOTH_POS1: pp = m1;
         BOOTH_POS2: pp = m2;
         BOOTH_NEG1: pp = -m1;
         BOOTH_NEG2: pp = -m2;
         default:    pp = '0;
      endcase
   end

endmodule

// File: rtl/seq_booth_r4_mult.sv
// Sequential radix-4 Booth multiplier, one digit per clock, signed or
// unsigned operands selected per operation, start/busy/done handshake.
module seq_booth_r4_mult
   import booth_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   // One extra digit beyond WIDTH/2 consumes the two extension bits, which
   // is what makes the unsigned top bit come out right.
   localparam int NDIG = WIDTH / 2 + 1;
   localparam int CW   = $clog2(NDIG);
   localparam int XW   = WIDTH + 2;
   localparam int AW   = WIDTH + 3;

   generate
      if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
         $error("seq_booth_r4_mult: WIDTH must be even and >= 4");
      end
   endgenerate

   booth_state_e     state;
   booth_state_e     state_nxt;
   logic             accept;
   logic [XW-1:0]    mcand_x;
   logic [XW-1:0]    q;
   logic             q_prev;
   logic [AW-1:0]    acc;
   logic [CW-1:0]    cnt;

   booth_digit_e     digit;
   logic [AW-1:0]    pp;
   logic [AW-1:0]    sum;
   logic [AW-1:0]    acc_nxt;
   logic [XW-1:0]    q_nxt;
   logic             q_prev_nxt;

   function automatic logic [XW-1:0] extend(input logic [WIDTH-1:0] v,
                                            input logic sm);
      return sm ? {{2{v[WIDTH-1]}}, v} : {2'b00, v};
   endfunction

   booth_r4_digit #(.WIDTH(WIDTH)) u_digit (
      .triplet (({q[1:0], q_prev})),
      .mcand   (mcand_x),
      .digit   (digit),
      .pp      (pp)
   );

   // Add the current partial product and arithmetic-shift the chain by 2.
   always_comb begin
      sum        = (digit == BOOTH_ZERO) ? acc : acc + pp;
      acc_nxt    = {{2{sum[AW-1]}}, sum[AW-1:2]};
      q_nxt      = {sum[1:0], q[XW-1:2]};
      q_prev_nxt = q[1];
   end

   // State register; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state, accept decode and handshake outputs.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (cnt == '0) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = ST_RUN;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Operand latch, accumulator chain, digit counter and product register.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_x <= '0;
         q       <= '0;
         q_prev  <= 1'b0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (accept) begin
         mcand_x <= extend(multiplicand, signed_mode);
         q       <= extend(multiplier, signed_mode);
         q_prev  <= 1'b0;
         acc     <= '0;
         cnt     <= CW'(NDIG - 1);
      end else if (state == ST_RUN) begin
         acc    <= acc_nxt;
         q      <= q_nxt;
         q_prev <= q_prev_nxt;
         cnt    <= cnt - CW'(1);
         if (cnt == '0) product <= {acc_nxt[WIDTH-3:0], q_nxt};
      end
   end

endmodule

// File: tb/tb_seq_booth_r4_mult.sv
// Self-checking bench for seq_booth_r4_mult (WIDTH=32) with a result
// scoreboard fed at issue time and drained on done.
module tb_seq_booth_r4_mult;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic           signed_mode;
   logic [W-1:0]   multiplicand;
   logic [W-1:0]   multiplier;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   int total = 0;
   int bad   = 0;
   logic [2*W-1:0] scb[$];

   seq_booth_r4_mult #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .signed_mode  (signed_mode),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [2*W-1:0] golden(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic sm);
      logic signed [2*W-1:0] sa;
      logic signed [2*W-1:0] sb;
      if (sm) begin
         sa = {{W{a[W-1]}}, a};
         sb = {{W{b[W-1]}}, b};
         return sa * sb;
      end
      return {{W{1'b0}}, a} * {{W{1'b0}}, b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one start pulse and log the expected result; operands are
   // scrambled afterwards so a late read of the inputs would show up.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sm);
      multiplicand = a;
      multiplier   = b;
      signed_mode  = sm;
      start        = 1'b1;
      scb.push_back(golden(a, b, sm));
      tick();
      start        = 1'b0;
      multiplicand = $urandom;
      multiplier   = $urandom;
      signed_mode  = ~sm;
   endtask

   // Step until done is seen or the cycle budget runs out.
   task automatic wait_done(output bit ok, output int cycles);
      cycles = 1;
      while (!done && cycles < 60) begin
         tick();
         cycles++;
      end
      ok = done;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; signed_mode = 1'b0;
      multiplicand = '0; multiplier = '0;
      tick(); tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
         bad++;
         $display("FAIL reset: busy=%b done=%b product=%h want 0 0 0", busy, done, product);
      end
      rst = 1'b0;
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_signed_basic();
      int errs;
      logic [2*W-1:0] exp;
      issue(32'hFFFF_FFF9, 32'd3, 1'b1);
      errs = 0;
      for (int i = 1; i <= 17; i++) begin
         if (busy !== 1'b1 || done !== 1'b0 || product !== '0) errs++;
         if (i < 17) tick();
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL busy_window: %0d bad cycles of 17, want busy=1 done=0 product held", errs);
      end
      tick();
      total++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL done_latency: cycle 18 busy=%b done=%b want 0 1", busy, done);
      end
      exp = scb.pop_front();
      total++;
      if (product !== exp || product !== 64'hFFFF_FFFF_FFFF_FFEB) begin
         bad++;
         $display("FAIL neg7x3: product=%h want %h", product, exp);
      end
      tick();
      total++;
      if (done !== 1'b0 || product !== 64'hFFFF_FFFF_FFFF_FFEB) begin
         bad++;
         $display("FAIL done_pulse: done=%b product=%h want 0, held", done, product);
      end
   endtask

   task automatic test_corners();
      logic [W-1:0]   ta [6];
      logic [W-1:0]   tb [6];
      logic           tm [6];
      logic [2*W-1:0] tk [6];
      logic [2*W-1:0] prev;
      logic [2*W-1:0] exp;
      bit ok;
      int cyc;
      ta[0] = 32'hFFFF_FFFF; tb[0] = 32'hFFFF_FFFF; tm[0] = 1'b0; tk[0] = 64'hFFFF_FFFE_0000_0001;
      ta[1] = 32'hFFFF_FFFF; tb[1] = 32'hFFFF_FFFF; tm[1] = 1'b1; tk[1] = 64'h1;
      ta[2] = 32'h8000_0000; tb[2] = 32'h8000_0000; tm[2] = 1'b1; tk[2] = 64'h4000_0000_0000_0000;
      ta[3] = 32'h8000_0000; tb[3] = 32'h1;         tm[3] = 1'b1; tk[3] = 64'hFFFF_FFFF_8000_0000;
      ta[4] = 32'h8000_0000; tb[4] = 32'h2;         tm[4] = 1'b0; tk[4] = 64'h1_0000_0000;
      ta[5] = 32'h0;         tb[5] = 32'h1234_5678; tm[5] = 1'b1; tk[5] = 64'h0;
      for (int i = 0; i < 6; i++) begin
         prev = product;
         tick();
         issue(ta[i], tb[i], tm[i]);
         total++;
         if (product !== prev) begin
            bad++;
            $display("FAIL hold_during_run[%0d]: product=%h want %h", i, product, prev);
         end
         wait_done(ok, cyc);
         exp = scb.pop_front();
         total++;
         if (!ok || cyc != 18 || product !== exp || product !== tk[i]) begin
            bad++;
            $display("FAIL corner[%0d]: done=%b cycle=%0d product=%h want 1 18 %h", i, ok, cyc, product, tk[i]);
         end
      end
   endtask

   task automatic test_restart_ignored();
      int dones;
      logic [2*W-1:0] exp;
      tick();
      issue(32'd5, 32'd6, 1'b0);
      dones = 0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 5) begin
            multiplicand = 32'd9; multiplier = 32'd9; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            dones++;
            exp = scb.pop_front();
            total++;
            if (product !== exp || product !== 64'd30) begin
               bad++;
               $display("FAIL restart_product: product=%h want %h", product, exp);
            end
         end
         tick();
      end
      start = 1'b0;
      total++;
      if (dones != 1) begin
         bad++;
         $display("FAIL restart_done_count: got %0d want 1", dones);
      end
   endtask

   task automatic test_reset_mid_run();
      int dones;
      bit ok;
      int cyc;
      logic [2*W-1:0] exp;
      tick();
      issue(32'd100, 32'd200, 1'b0);
      for (int i = 1; i < 8; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      scb.delete();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
         bad++;
         $display("FAIL abort: busy=%b done=%b product=%h want 0 0 0", busy, done, product);
      end
      dones = 0;
      for (int i = 0; i < 25; i++) begin
         if (done) dones++;
         tick();
      end
      total++;
      if (dones != 0) begin
         bad++;
         $display("FAIL abort_no_done: got %0d want 0", dones);
      end
      issue(32'd12, 32'hFFFF_FFFC, 1'b1);
      wait_done(ok, cyc);
      exp = scb.pop_front();
      total++;
      if (!ok || product !== exp || product !== 64'hFFFF_FFFF_FFFF_FFD0) begin
         bad++;
         $display("FAIL post_abort: done=%b product=%h want 1 %h", ok, product, exp);
      end
   endtask

   task automatic test_back_to_back();
      localparam int N = 24;
      int issued;
      int got;
      int cyc;
      int last;
      logic [2*W-1:0] exp;
      tick();
      multiplicand = $urandom;
      multiplier   = $urandom;
      signed_mode  = 1'($urandom);
      start        = 1'b1;
      scb.push_back(golden(multiplicand, multiplier, signed_mode));
      issued = 1; got = 0; cyc = 0; last = 0;
      while (got < N && cyc < N * 18 + 100) begin
         tick();
         cyc++;
         if (done) begin
            got++;
            total++;
            if (scb.size() == 0) begin
               bad++;
               $display("FAIL b2b_unexpected_done: cycle=%0d product=%h want no done", cyc, product);
            end else begin
               exp = scb.pop_front();
               if (product !== exp || cyc - last != 18) begin
                  bad++;
                  $display("FAIL b2b[%0d]: product=%h interval=%0d want %h 18", got, product, cyc - last, exp);
               end
            end
            last = cyc;
            if (issued < N) begin
               multiplicand = $urandom;
               multiplier   = $urandom;
               signed_mode  = 1'($urandom);
               scb.push_back(golden(multiplicand, multiplier, signed_mode));
               issued++;
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      total++;
      if (got != N) begin
         bad++;
         $display("FAIL b2b_timeout: results=%0d want %0d", got, N);
      end
      tick(); tick();
      total++;
      if (busy !== 1'b0 || scb.size() != 0) begin
         bad++;
         $display("FAIL b2b_drain: busy=%b pending=%0d want 0 0", busy, scb.size());
      end
   endtask

   initial begin
      test_reset();
      test_signed_basic();
      test_corners();
      test_restart_ignored();
      test_reset_mid_run();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
